// File: rtl/mul_share_arbiter_pkg.sv
// Shared constants, operand/product types and the tag-width helper for the
// shared 16x7 signed multiplier arbiter.
package mul_share_arbiter_pkg;

   localparam int MUL_A_W = 16;
   localparam int MUL_B_W = 7;
   localparam int MUL_P_W = 23;
   localparam int MUL_LAT = 4;

   typedef logic signed [MUL_A_W-1:0] mul_a_t;
   typedef logic signed [MUL_B_W-1:0] mul_b_t;
   typedef logic signed [MUL_P_W-1:0] mul_p_t;

   // Width needed to index n items, never less than one bit.
   function automatic int clog2_min1(input int n);
      int w;
      w = 32'sd0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < n) begin
            w = i + 32'sd1;
         end
      end
      return (w < 32'sd1) ? 32'sd1 : w;
   endfunction

endpackage

// File: rtl/mul_share_arbiter_if.sv
// Requester and result bus of the shared multiplier arbiter.
interface mul_share_arbiter_if
   import mul_share_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int TAG_W   = clog2_min1(NUM_REQ)
);

   logic [NUM_REQ-1:0]         req_en;
   logic [NUM_REQ-1:0]         req_valid;
   logic [NUM_REQ-1:0]         req_ready;
   logic [NUM_REQ*MUL_A_W-1:0] req_a;
   logic [NUM_REQ*MUL_B_W-1:0] req_b;
   logic                       res_valid;
   logic                       res_ready;
   logic [TAG_W-1:0]           res_tag;
   logic [MUL_P_W-1:0]         res_data;
   logic                       busy;

   modport slave (
      input  req_en, req_valid, req_a, req_b, res_ready,
      output req_ready, res_valid, res_tag, res_data, busy
   );

   modport master (
      output req_en, req_valid, req_a, req_b, res_ready,
      input  req_ready, res_valid, res_tag, res_data, busy
   );

endinterface

// File: rtl/mul_share_arbiter_mul_pipe.sv
// Three-register signed 16x7 multiplier core; left unreset so it packs into
// a single DSP slice.
module mul_pipe_s16_s7
   import mul_share_arbiter_pkg::*;
(
   input  logic   clk,
   input  logic   ce,
   input  mul_a_t a,
   input  mul_b_t b,
   output mul_p_t p
);

   mul_a_t a_q;
   mul_b_t b_q;
   mul_p_t p1_q;
   mul_p_t p2_q;

   // Operand, product and product-pipeline registers, all held when ce is low.
   always_ff @(posedge clk) begin
      if (ce) begin
         a_q  <= a;
         b_q  <= b;
         p1_q <= mul_p_t'(a_q) * mul_p_t'(b_q);
         p2_q <= p1_q;
      end
   end

   assign p = p2_q;

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one pipelined signed multiplier between NUM_REQ
// requesters; results return in issue order tagged with the requester index.
module mul_share_arbiter
   import mul_share_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int TAG_W   = clog2_min1(NUM_REQ)
) (
   input  logic               clk,
   input  logic               reset,
   mul_share_arbiter_if.slave bus
);

   localparam int CHAIN = MUL_LAT - 1;

   logic               ce_s;
   logic               hs_s;
   logic [NUM_REQ-1:0] elig_s;
   logic [NUM_REQ-1:0] onehot_s;
   logic               gnt_any_s;
   logic [TAG_W-1:0]   gnt_idx_s;
   logic [TAG_W-1:0]   ptr_q;
   logic [TAG_W-1:0]   ptr_d;
   logic [CHAIN-1:0]   vld_q;
   logic [TAG_W-1:0]   tag_q [CHAIN];
   logic               res_valid_q;
   logic [TAG_W-1:0]   res_tag_q;
   mul_p_t             res_data_q;
   mul_a_t             mul_a_s;
   mul_b_t             mul_b_s;
   mul_p_t             mul_p_s;

   assign ce_s   = ~res_valid_q | bus.res_ready;
   assign elig_s = bus.req_valid & bus.req_en;

   // Round-robin search from the pointer; scanning downwards lets the
   // eligible requester nearest the pointer win the last assignment.
   always_comb begin
      int cand;
      cand      = 32'sd0;
      gnt_idx_s = '0;
      gnt_any_s = 1'b0;
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
         cand      = int'(ptr_q) + off;
         cand      = (cand >= NUM_REQ) ? (cand - NUM_REQ) : cand;
         gnt_idx_s = elig_s[cand] ? TAG_W'(cand) : gnt_idx_s;
         gnt_any_s = gnt_any_s | elig_s[cand];
      end
   end

   assign hs_s     = gnt_any_s & ce_s & reset;
   assign onehot_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_idx_s;

   // Grant output, pointer advance and operand mux for the winning requester.
   always_comb begin
      bus.req_ready = '0;
      ptr_d         = ptr_q;
      mul_a_s       = bus.req_a[int'(gnt_idx_s)*MUL_A_W +: MUL_A_W];
      mul_b_s       = bus.req_b[int'(gnt_idx_s)*MUL_B_W +: MUL_B_W];
      if (hs_s) begin
         bus.req_ready = onehot_s;
         ptr_d         = (gnt_idx_s == TAG_W'(NUM_REQ - 1)) ? '0 : gnt_idx_s + TAG_W'(32'd1);
      end else begin
         bus.req_ready = '0;
         ptr_d         = ptr_q;
      end
   end

   mul_pipe_s16_s7 u_mul (
      .clk (clk),
      .ce  (ce_s),
      .a   (mul_a_s),
      .b   (mul_b_s),
      .p   (mul_p_s)
   );

   // Pointer, valid/tag chain alongside the multiplier, and the output register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         ptr_q       <= '0;
         vld_q       <= '0;
         res_valid_q <= 1'b0;
         res_tag_q   <= '0;
         res_data_q  <= '0;
         for (int i = 0; i < CHAIN; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         ptr_q <= ptr_d;
         if (ce_s) begin
            vld_q    <= {vld_q[CHAIN-2:0], hs_s};
            tag_q[0] <= gnt_idx_s;
            for (int i = 1; i < CHAIN; i++) begin
               tag_q[i] <= tag_q[i-1];
            end
            res_valid_q <= vld_q[CHAIN-1];
            res_tag_q   <= tag_q[CHAIN-1];
            res_data_q  <= mul_p_s;
         end
      end
   end

   assign bus.res_valid = res_valid_q;
   assign bus.res_tag   = res_tag_q;
   assign bus.res_data  = res_data_q;
   assign bus.busy      = (|vld_q) | res_valid_q;

endmodule
